param_counter: RTL and testbench

Parametrised up/down step counter with an enable input, synchronous load, programmable terminal limit, wrap or saturate mode, a terminal-count pulse, a sticky overflow flag and a divide-by-terminal toggle output. It generalises the free-running bit toggle and 10-bit incrementer pattern into a reusable block. It is used as a timebase, event counter or stimulus generator in designs and benches.

---
 rtl/param_counter_pkg.sv | 36 +++
 rtl/counter_prescaler.sv | 28 ++
 rtl/param_counter.sv | 84 ++++++++
 tb/tb_param_counter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/param_counter_pkg.sv
// Shared constants, step result type and next-count function for param_counter.
// Optional feature macro: PARAM_COUNTER_PRESCALE_EN (see param_counter.sv).
package param_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Widest counter the shared function supports; callers cast to their WIDTH.
    localparam int unsigned CALC_W = 64;

    typedef struct packed {
        logic [CALC_W-1:0] nxt;
        logic              term;
    } step_res_t;

    // Terminal test uses the pre-step count; non-terminal steps never leave [0, limit].
    function automatic step_res_t next_count(input logic [CALC_W-1:0] count,
                                             input logic [CALC_W-1:0] limit,
                                             input logic              dir,
                                             input logic              mode);
        step_res_t r;
        if (dir == DIR_UP) begin
            r.term = (count >= limit);
            if (r.term) r.nxt = (mode == MODE_SAT) ? limit : '0;
            else        r.nxt = count + CALC_W'(1);
        end else begin
            r.term = (count == '0);
            if (r.term) r.nxt = (mode == MODE_SAT) ? '0 : limit;
            else        r.nxt = count - CALC_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step strobe generator: one strobe every PRESCALE enabled cycles.
// Only instantiated when PARAM_COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic step_c
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign step_c = en && (pre == LAST);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == LAST) ? '0 : pre + PW'(1);
        end
    end

endmodule

// File: rtl/param_counter.sv
// Up/down step counter with load, programmable limit, wrap/saturate, tc pulse, toggle and sticky ovf.
// Define PARAM_COUNTER_PRESCALE_EN to add the PRESCALE parameter and a step prescaler.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned RESET_VAL = 0
`ifdef PARAM_COUNTER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE  = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             toggle,
    output logic             ovf
);

    logic step_c;

`ifdef PARAM_COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .step_c (step_c)
    );
`else
    assign step_c = en;
`endif

    step_res_t        res;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             toggle_nxt;
    logic             ovf_nxt;
    logic             unused_hi;

    // Next-state: load beats step; ovf set wins over clr_ovf.
    always_comb begin
        res        = next_count(CALC_W'(count), CALC_W'(limit), dir, mode);
        count_nxt  = count;
        tc_nxt     = 1'b0;
        toggle_nxt = toggle;
        ovf_nxt    = ovf & ~clr_ovf;
        if (load) begin
            count_nxt = load_val;
        end else if (step_c) begin
            count_nxt  = WIDTH'(res.nxt);
            tc_nxt     = res.term;
            toggle_nxt = toggle ^ res.term;
            ovf_nxt    = ovf_nxt | res.term;
        end
    end

    assign unused_hi = ^res.nxt[CALC_W-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= WIDTH'(RESET_VAL);
            tc     <= 1'b0;
            toggle <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            count  <= count_nxt;
            tc     <= tc_nxt;
            toggle <= toggle_nxt;
            ovf    <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: directed scenarios plus random stimulus against a behavioural model.
// Honours PARAM_COUNTER_PRESCALE_EN (model tracks the prescaler; fixed-value checks assume no prescale).
module tb_param_counter;

    localparam int unsigned W   = 10;
    localparam int unsigned RV  = 0;
    localparam int unsigned MOD = 1 << W;
`ifdef PARAM_COUNTER_PRESCALE_EN
    localparam int unsigned PS = 4;
`else
    localparam int unsigned PS = 1;
`endif

    logic         clk = 1'b0;
    logic         rst, en, load, dir, mode, clr_ovf;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] count;
    logic         tc, toggle, ovf;

    int vectors     = 0;
    int miscompares = 0;

    int m_cnt, m_pre;
    bit m_tc, m_tog, m_ovf;

    always #5 clk = ~clk;

    param_counter #(
        .WIDTH     (W),
        .RESET_VAL (RV)
`ifdef PARAM_COUNTER_PRESCALE_EN
        ,
        .PRESCALE  (PS)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .mode     (mode),
        .limit    (limit),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .toggle   (toggle),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural reference: one clock edge using the inputs presented at that edge.
    task automatic model_edge();
        bit stp, term;
        int lim;
        lim = int'(limit);
        if (rst) begin
            m_cnt = RV; m_tc = 0; m_tog = 0; m_ovf = 0; m_pre = 0;
            return;
        end
        if (load) begin
            m_cnt = int'(load_val); m_tc = 0; m_pre = 0;
            if (clr_ovf) m_ovf = 0;
            return;
        end
        stp = 0;
        if (en) begin
            if (m_pre == PS - 1) begin stp = 1; m_pre = 0; end
            else m_pre = m_pre + 1;
        end
        term = dir ? (m_cnt >= lim) : (m_cnt == 0);
        if (stp) begin
            if (dir) m_cnt = term ? (mode ? lim : 0) : (m_cnt + 1) % MOD;
            else     m_cnt = term ? (mode ? 0 : lim) : (m_cnt + MOD - 1) % MOD;
        end
        m_tc = stp && term;
        if (m_tc) m_tog = !m_tog;
        if (m_tc) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("count",  32'(count),  32'(m_cnt));
        chk("tc",     32'(tc),     32'(m_tc));
        chk("toggle", 32'(toggle), 32'(m_tog));
        chk("ovf",    32'(ovf),    32'(m_ovf));
    endtask

    task automatic expect_c(input string tag, input int c, input bit t, input bit tg, input bit o);
        chk({tag, ".count"},  32'(count),  32'(c));
        chk({tag, ".tc"},     32'(tc),     32'(t));
        chk({tag, ".toggle"}, 32'(toggle), 32'(tg));
        chk({tag, ".ovf"},    32'(ovf),    32'(o));
    endtask

    initial begin
        rst = 1; en = 0; load = 0; load_val = '0; dir = 1; mode = 0;
        limit = W'(1023); clr_ovf = 0;
        m_cnt = RV; m_pre = 0; m_tc = 0; m_tog = 0; m_ovf = 0;

        // Reset, then full-range wrap run
        repeat (2) cycle();
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("reset", 0, 0, 0, 0);
`endif
        rst = 0; en = 1;
        repeat (1030) cycle();
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("wrap1023", 6, 0, 1, 1);
`endif

        // Small limit wrap: 10 steps = two terminal events
        rst = 1; cycle(); rst = 0;
        limit = W'(4);
        repeat (10) cycle();
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("wrap4", 0, 1, 0, 1);
`endif

        // Load 3 then saturating down-count
        load = 1; load_val = W'(3); cycle(); load = 0;
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("load3", 3, 0, 0, 1);
`endif
        dir = 0; mode = 1; en = 1;
        repeat (3) cycle();
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("sat_reach0", 0, 0, 0, 1);
`endif
        cycle();
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("sat_first", 0, 1, 1, 1);
`endif
        cycle();
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("sat_repeat", 0, 1, 0, 1);
`endif

        // Load beats step
        rst = 1; cycle(); rst = 0;
        dir = 1; mode = 0; limit = W'(1023);
        repeat (10) cycle();
        load = 1; load_val = W'(500); cycle(); load = 0;
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("load_over_en", 500, 0, 0, 0);
`endif

        // ovf set wins over clear, then clear alone
        rst = 1; cycle(); rst = 0;
        limit = W'(4);
        repeat (4) cycle();
        clr_ovf = 1; cycle();
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("ovf_set_wins", 0, 1, 1, 1);
`endif
        en = 0; cycle(); clr_ovf = 0;
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("ovf_clear", 0, 0, 1, 0);
`endif

        // Mid-run reset
        load = 1; load_val = W'(700); limit = W'(1023); cycle(); load = 0;
        en = 1; rst = 1; cycle(); rst = 0;
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("mid_reset", 0, 0, 0, 0);
`endif
        repeat (2) cycle();
`ifndef PARAM_COUNTER_PRESCALE_EN
        expect_c("resume", 2, 0, 0, 0);
`endif

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 19) == 0);
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom_range(0, 1));
            mode     = 1'($urandom_range(0, 1));
            clr_ovf  = ($urandom_range(0, 7) == 0);
            load_val = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 12)) : W'($urandom);
            case ($urandom_range(0, 3))
                0:       limit = W'($urandom_range(0, 2));
                1:       limit = W'($urandom);
                default: limit = W'($urandom_range(3, 12));
            endcase
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
